// File: rtl/sgd_momentum_seq.sv
// Sequential SGD / SGD-with-momentum optimizer: walks the flattened {w, b} vector
// LANES elements per clock, keeps a persistent velocity buffer, saturates all arithmetic.
module sgd_momentum_seq #(
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     clear_vel_i,
  input  logic                     momentum_en_i,
  input  logic [WIDTH-1:0]         lr_i,
  input  logic [WIDTH-1:0]         mu_i,
  input  logic [M*N*N*WIDTH-1:0]   w_i,
  input  logic [M*N*N*WIDTH-1:0]   dl_dw_i,
  input  logic [N*M*WIDTH-1:0]     b_i,
  input  logic [N*M*WIDTH-1:0]     dl_db_i,
  output logic [M*N*N*WIDTH-1:0]   w_new_o,
  output logic [N*M*WIDTH-1:0]     b_new_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int NW    = M*N*N;
  localparam int NB    = N*M;
  localparam int P     = NW + NB;
  // Arrays are padded to a power of two so the lane index never selects out of range.
  localparam int AW    = $clog2(P + LANES);
  localparam int DEPTH = 1 << AW;

  typedef logic signed [WIDTH-1:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam word_t MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam word_t MINV = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic word_t fx_mul(input word_t a, input word_t b);
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] sh;
    prod = a * b;
    sh   = prod >>> FRAC;
    if (!sh[2*WIDTH-1] && (|sh[2*WIDTH-2:WIDTH-1]))
      return MAXV;
    else if (sh[2*WIDTH-1] && !(&sh[2*WIDTH-2:WIDTH-1]))
      return MINV;
    else
      return sh[WIDTH-1:0];
  endfunction

  function automatic word_t sat1(input logic signed [WIDTH:0] s);
    if (s[WIDTH] != s[WIDTH-1])
      return s[WIDTH] ? MINV : MAXV;
    else
      return s[WIDTH-1:0];
  endfunction

  function automatic word_t fx_add(input word_t a, input word_t b);
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    return sat1(s);
  endfunction

  function automatic word_t fx_sub(input word_t a, input word_t b);
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    return sat1(s);
  endfunction

  state_t          state_q, state_d;
  logic [AW-1:0]   k_q, k_d;
  word_t           lr_q, lr_d, mu_q, mu_d;
  logic            mom_q, mom_d;
  word_t           vel_q  [DEPTH];
  word_t           vel_d  [DEPTH];
  word_t           pnew_q [DEPTH];
  word_t           pnew_d [DEPTH];
  word_t           p_arr  [DEPTH];
  word_t           g_arr  [DEPTH];
  logic [P*WIDTH-1:0] params, grads, out_flat;

  assign params = {w_i, b_i};
  assign grads  = {dl_dw_i, dl_db_i};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      p_arr[i] = '0;
      g_arr[i] = '0;
    end
    for (int i = 0; i < P; i++) begin
      p_arr[i] = params[i*WIDTH +: WIDTH];
      g_arr[i] = grads[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    logic [AW-1:0] idx;
    word_t         v_new;
    word_t         step;
    state_d = state_q;
    k_d     = k_q;
    lr_d    = lr_q;
    mu_d    = mu_q;
    mom_d   = mom_q;
    vel_d   = vel_q;
    pnew_d  = pnew_q;
    idx     = '0;
    v_new   = '0;
    step    = '0;
    case (state_q)
      IDLE: begin
        if (clear_vel_i) begin
          for (int i = 0; i < DEPTH; i++) vel_d[i] = '0;
        end
        if (start_i) begin
          state_d = RUN;
          k_d     = '0;
          lr_d    = lr_i;
          mu_d    = mu_i;
          mom_d   = momentum_en_i;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          idx = k_q + AW'(l);
          if (idx < AW'(P)) begin
            v_new = fx_add(fx_mul(mu_q, vel_q[idx]), g_arr[idx]);
            step  = mom_q ? v_new : g_arr[idx];
            pnew_d[idx] = fx_sub(p_arr[idx], fx_mul(lr_q, step));
            if (mom_q) vel_d[idx] = v_new;
          end
        end
        k_d = k_q + AW'(LANES);
        if (({1'b0, k_q} + (AW+1)'(LANES)) >= (AW+1)'(P)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      lr_q    <= '0;
      mu_q    <= '0;
      mom_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        vel_q[i]  <= '0;
        pnew_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lr_q    <= lr_d;
      mu_q    <= mu_d;
      mom_q   <= mom_d;
      for (int i = 0; i < DEPTH; i++) begin
        vel_q[i]  <= vel_d[i];
        pnew_q[i] <= pnew_d[i];
      end
    end
  end

  always_comb begin
    out_flat = '0;
    for (int i = 0; i < P; i++) out_flat[i*WIDTH +: WIDTH] = pnew_q[i];
  end

  assign b_new_o = out_flat[NB*WIDTH-1:0];
  assign w_new_o = out_flat[P*WIDTH-1:NB*WIDTH];
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);

endmodule

// File: doc/sgd_momentum_seq.md
# sgd_momentum_seq

Sequential, parametrised successor to the combinational SGD update. It steps the flattened parameter vector {w, b} through a configurable number of update lanes per clock. It keeps a per-parameter velocity buffer, so it can run either plain SGD or SGD with momentum, and it saturates instead of wrapping. It sits after the backward pass in the training loop: the trainer asserts `start`, waits for `done`, then feeds `w_new`/`b_new` back as the next `w`/`b`.

## Interface
- `N`, default 4: layer width, as in the forward/backward blocks.
- `M`, default 4: layer count.
- `WIDTH`, default 16: signed fixed-point word width.
- `FRAC`, default 8: fractional bits. Default format is Q8.8.
- `LANES`, default 1: parameters updated per cycle. Range 1..P, where P = M*N*N + N*M.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to run one optimizer step. Honoured only in IDLE.
- `clear_vel`  in  1  zero the whole velocity buffer. Honoured only in IDLE.
- `momentum_en`  in  1  1 selects momentum update, 0 selects plain SGD. Sampled with `start`.
- `lr`  in  WIDTH  learning rate, signed Q(WIDTH-FRAC).FRAC. Sampled with `start`.
- `mu`  in  WIDTH  momentum coefficient, same format. Sampled with `start`.
- `w`, `dL_dw`  in  M*N*N*WIDTH  current weights and their gradients.
- `b`, `dL_db`  in  N*M*WIDTH  current biases and their gradients.
- `w_new`  out  M*N*N*WIDTH  updated weights, registered.
- `b_new`  out  N*M*WIDTH  updated biases, registered.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse in DONE. Outputs are complete and stable from this cycle on.

## Operation
- Flattening: params = {w, b} and grads = {dL_dw, dL_db}. Element i occupies bits [i*WIDTH +: WIDTH]. Index 0 is the low word of `b`, and indices P-1 down to N*M are the words of `w`.
- Velocity buffer: P registers of WIDTH bits each. It persists across steps and is changed only by momentum updates, `clear_vel`, or reset.
- Fixed-point multiply mul(a,b):
  - Form the full 2*WIDTH signed product.
  - Arithmetic right shift by FRAC, which floors toward minus infinity.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Add and subtract are computed at WIDTH+1 bits, then saturated to WIDTH bits. Nothing wraps.
- Per element, plain mode (`momentum_en`=0):
  - p' = sat(p - mul(lr, g)).
  - Velocity is left untouched.
- Per element, momentum mode:
  - v' = sat(mul(mu, v) + g).
  - p' = sat(p - mul(lr, v')).
  - v' is written back to the velocity buffer.
- State machine:
  - IDLE -> RUN on `start`. This clears index counter k to 0 and latches lr, mu and `momentum_en`.
  - RUN: each cycle updates elements k..min(k+LANES, P)-1, writing their `w_new`/`b_new` slices and velocity entries, then sets k += LANES.
  - RUN -> DONE in the cycle that processes index P-1.
  - DONE -> IDLE unconditionally.
- Inputs `w`, `b`, `dL_dw` and `dL_db` must be held stable while `busy` is high. Verification asserts this; the block does not latch them.
- `start` while busy: ignored, no queueing.
- `clear_vel` in IDLE zeros all P velocity entries at the next edge.
- `start` and `clear_vel` in the same IDLE cycle: the clear wins first. The step then runs with v = 0 for every element.
- `clear_vel` while busy: ignored.
- Elements of `w_new`/`b_new` not yet reached in RUN keep their previous values. Partial results are visible but meaningful only at or after `done`.

## Timing
- Reset (asynchronous, on `rst_n` low): state IDLE, k = 0, `busy` = 0, `done` = 0, `w_new` = 0, `b_new` = 0, all velocity entries = 0, latched lr/mu/mode = 0.
- Reset asserted mid-RUN aborts the step immediately with the same values. The first `start` after `rst_n` rises is honoured normally.
- `start` sampled at edge t0: `busy` = 1 from t0.
- RUN lasts R = ceil(P/LANES) cycles. The last group may be partial when LANES does not divide P; lanes past P-1 are inert.
- `done` = 1 for the single cycle after the last RUN edge. Latency from `start` edge to `done` is R+1 cycles.
- `busy` falls together with `done` going low, and the next `start` may be issued in that same cycle.
- Back-to-back throughput: one step every R+2 cycles.
- The arithmetic path is one combinational stage per lane between registers; there is no internal pipelining.

## Test plan
- Plain SGD, N=2, M=2 (P=12), LANES=1. All w = 0x0100, all g = 0x0200, lr = 0x0080 -> every w_new/b_new word = 0x0000. `done` arrives 13 cycles after `start`. Velocity reads all 0.
- Momentum, same values, mu = 0x0080.
  - Step 1 -> p' = 0x0000, v = 0x0200.
  - Step 2 with p re-fed as 0x0100 -> v = 0x0300, p' = 0xFF80.
- Saturation: p = 0x8100, g = 0x7F00, lr = 0x0100, plain -> p' = 0x8000. No wrap to a positive value.
- Rounding: lr = 0x0001, g = 0xFFFF, p = 0x0000 -> mul = floor(-1/256) = 0xFFFF, so p' = 0x0001.
- Timing and control, P=12, LANES=5:
  - R = 3; `done` 4 cycles after `start`.
  - A `start` pulse mid-RUN is ignored.
  - `start` together with `clear_vel` runs with v = 0.
- Reset mid-RUN after 2 cycles: all outputs read 0, `busy` = 0, velocity is 0. A following step completes normally.
